// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART register-write frame receiver:
// FSM state encoding, abort cause codes and the default frame marker.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        ST_HUNT    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_LEN     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CHECK   = 3'd4,
        ST_DRAIN   = 3'd5
    } frame_state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CSUM    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload holding buffer: DEPTH x DATA_W register file with one synchronous
// write port and one asynchronous read port; out-of-range reads return zero.
module uart_frame_buf
    import uart_frame_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int IDX_W  = 5,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int A_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we && (waddr < IDX_W'(DEPTH))) begin
            mem[waddr[A_W-1:0]] <= wdata;
        end
    end

    assign rdata = (raddr < IDX_W'(DEPTH)) ? mem[raddr[A_W-1:0]] : '0;

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Turns the uart_receiver byte stream into checksum-verified register-write bursts:
// SYNC, ADDR, LEN, payload, CSUM; payload is replayed as write beats only after CSUM matches.
module uart_rx_frame_ctrl
    import uart_frame_pkg::*;
#(
    parameter int         MAX_LEN        = 16,
    parameter int         TIMEOUT_CYCLES = 5120,
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
    input  logic       uart_sampling_clk,
    input  logic       reset,
    input  logic       rx_valid,
    output logic       rx_ready,
    input  logic [7:0] rx_data,
    output logic       wr_valid,
    input  logic       wr_ready,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       frame_done,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       busy
);

    localparam int               IDX_W     = $clog2(MAX_LEN + 1);
    localparam int               GAP_W     = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(TIMEOUT_CYCLES - 1);

    frame_state_t     state, state_nxt;
    logic [7:0]       base_addr;
    logic [7:0]       csum;
    logic [IDX_W-1:0] len;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] buf_raddr;
    logic [GAP_W-1:0] gap_cnt;
    logic [7:0]       buf_rdata;
    logic             buf_we;

    logic             rx_accept;
    logic             beat;
    logic             in_frame;
    logic             timeout;
    logic             len_bad;
    logic             csum_ok;
    logic             idx_last;
    logic             err_set;
    logic [1:0]       err_nxt;
    logic             done_set;

    assign rx_accept = rx_valid && rx_ready;
    assign beat      = wr_valid && wr_ready;
    assign in_frame  = (state == ST_ADDR) || (state == ST_LEN) ||
                       (state == ST_PAYLOAD) || (state == ST_CHECK);
    // An accepted byte on the limit cycle takes precedence over the timeout.
    assign timeout   = in_frame && !rx_accept && (gap_cnt == GAP_LIMIT);
    assign len_bad   = (rx_data == 8'd0) || (rx_data > MAX_LEN_B);
    assign csum_ok   = (rx_data == csum);
    assign idx_last  = (idx == len - IDX_W'(1));
    assign buf_we    = (state == ST_PAYLOAD) && rx_accept;
    // During DRAIN the buffer is read one entry ahead so the next beat is ready on handshake.
    assign buf_raddr = (state == ST_DRAIN) ? idx + IDX_W'(1) : '0;

    uart_frame_buf #(
        .DEPTH  (MAX_LEN),
        .IDX_W  (IDX_W),
        .DATA_W (8)
    ) u_buf (
        .clk   (uart_sampling_clk),
        .we    (buf_we),
        .waddr (idx),
        .wdata (rx_data),
        .raddr (buf_raddr),
        .rdata (buf_rdata)
    );

    always_ff @(posedge uart_sampling_clk) begin
        if (reset) begin
            state <= ST_HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_HUNT: begin
                if (rx_accept && (rx_data == SYNC_BYTE)) state_nxt = ST_ADDR;
            end
            ST_ADDR: begin
                if (rx_accept)    state_nxt = ST_LEN;
                else if (timeout) state_nxt = ST_HUNT;
            end
            ST_LEN: begin
                if (rx_accept)    state_nxt = len_bad ? ST_HUNT : ST_PAYLOAD;
                else if (timeout) state_nxt = ST_HUNT;
            end
            ST_PAYLOAD: begin
                if (rx_accept && idx_last) state_nxt = ST_CHECK;
                else if (timeout)          state_nxt = ST_HUNT;
            end
            ST_CHECK: begin
                if (rx_accept)    state_nxt = csum_ok ? ST_DRAIN : ST_HUNT;
                else if (timeout) state_nxt = ST_HUNT;
            end
            ST_DRAIN: begin
                if (beat && idx_last) state_nxt = ST_HUNT;
            end
            default: state_nxt = ST_HUNT;
        endcase
    end

    always_comb begin
        rx_ready = (state != ST_DRAIN);
        busy     = (state != ST_HUNT);
        done_set = (state == ST_DRAIN) && beat && idx_last;
        err_set  = 1'b0;
        err_nxt  = ERR_NONE;
        if (timeout) begin
            err_set = 1'b1;
            err_nxt = ERR_TIMEOUT;
        end else if ((state == ST_LEN) && rx_accept && len_bad) begin
            err_set = 1'b1;
            err_nxt = ERR_LEN;
        end else if ((state == ST_CHECK) && rx_accept && !csum_ok) begin
            err_set = 1'b1;
            err_nxt = ERR_CSUM;
        end
    end

    always_ff @(posedge uart_sampling_clk) begin
        if (reset) begin
            base_addr  <= 8'd0;
            csum       <= 8'd0;
            len        <= '0;
            idx        <= '0;
            gap_cnt    <= '0;
            wr_valid   <= 1'b0;
            wr_addr    <= 8'd0;
            wr_data    <= 8'd0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            err_code   <= ERR_NONE;
        end else begin
            frame_done <= done_set;
            frame_err  <= err_set;
            if (err_set) err_code <= err_nxt;

            if (!in_frame || rx_accept || timeout) gap_cnt <= '0;
            else                                   gap_cnt <= gap_cnt + GAP_W'(1);

            case (state)
                ST_ADDR: begin
                    if (rx_accept) begin
                        base_addr <= rx_data;
                        csum      <= rx_data;
                    end
                end
                ST_LEN: begin
                    if (rx_accept && !len_bad) begin
                        len  <= rx_data[IDX_W-1:0];
                        csum <= csum ^ rx_data;
                        idx  <= '0;
                    end
                end
                ST_PAYLOAD: begin
                    if (rx_accept) begin
                        csum <= csum ^ rx_data;
                        idx  <= idx + IDX_W'(1);
                    end
                end
                ST_CHECK: begin
                    if (rx_accept && csum_ok) begin
                        idx      <= '0;
                        wr_valid <= 1'b1;
                        wr_addr  <= base_addr;
                        wr_data  <= buf_rdata;
                    end
                end
                ST_DRAIN: begin
                    if (beat) begin
                        if (idx_last) begin
                            wr_valid <= 1'b0;
                            idx      <= '0;
                        end else begin
                            idx     <= idx + IDX_W'(1);
                            wr_addr <= wr_addr + 8'd1;
                            wr_data <= buf_rdata;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
